commit_trace_buffer: RTL

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

---
 rtl/trace_pkg.sv | 19 +
 rtl/trace_fifo.sv | 47 ++++
 rtl/commit_trace_buffer.sv | 111 +++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared record layout and constants for the commit trace buffer.
package trace_pkg;

    localparam int KIND_REGWRITE = 0;
    localparam int KIND_STORE    = 1;
    localparam int KIND_LOAD     = 2;

    localparam int DROP_W  = 8;
    localparam int CYCLE_W = 16;

    typedef struct packed {
        logic [2:0] kind;
        logic [4:0] reg_num;
        logic [8:0] addr;
    } trace_meta_t;

    localparam int META_W = $bits(trace_meta_t);

endpackage

// File: rtl/trace_fifo.sv
// Record storage for the commit trace buffer: circular array with wrap-bit pointers.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_vld,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_vld = !empty;
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign do_push  = push && (!full || do_pop);

    assign head_data = head_vld ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures register-writeback and data-memory events into a FIFO of trace records.
// Define TRACE_TIMESTAMP_EN to stamp each record with a free-running 16-bit cycle count.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trace_en,
    input  logic              reg_write_sig,
    input  logic [4:0]        reg_num,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              wr,
    input  logic              rd,
    input  logic [8:0]        addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_kind,
    output logic [4:0]        out_reg_num,
    output logic [DATA_W-1:0] out_reg_data,
    output logic [8:0]        out_addr,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [15:0]       out_cycle,
    output logic [7:0]        drop_count,
    output logic              full,
    output logic              empty
);
`ifdef TRACE_TIMESTAMP_EN
    localparam int REC_W = META_W + 2 * DATA_W + CYCLE_W;
`else
    localparam int REC_W = META_W + 2 * DATA_W;
`endif

    logic              rw_hit_p0;
    logic              evt_p0;
    trace_meta_t       meta_p0;
    logic [DATA_W-1:0] reg_data_p0;
    logic [DATA_W-1:0] mem_data_p0;
    logic [REC_W-1:0]  push_rec;
    logic [REC_W-1:0]  head_rec;
    trace_meta_t       head_meta;
    logic              pop;
    logic [DROP_W-1:0] drop_cnt;

    // Capture stage: build the record, zeroing fields the event does not use.
    always_comb begin
        rw_hit_p0 = reg_write_sig && (reg_num != 5'd0);
        evt_p0    = reset && trace_en && (rw_hit_p0 || wr || rd);
        meta_p0   = '0;
        meta_p0.kind[KIND_REGWRITE] = rw_hit_p0;
        meta_p0.kind[KIND_STORE]    = wr;
        meta_p0.kind[KIND_LOAD]     = rd;
        meta_p0.reg_num = rw_hit_p0 ? reg_num : 5'd0;
        meta_p0.addr    = (wr || rd) ? addr : 9'd0;
        reg_data_p0 = rw_hit_p0 ? reg_data : '0;
        mem_data_p0 = wr ? wr_data : (rd ? rd_data : '0);
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [CYCLE_W-1:0] cycle_cnt;

    always_ff @(posedge clk) begin
        if (!reset) cycle_cnt <= '0;
        else        cycle_cnt <= cycle_cnt + 1'b1;
    end

    assign push_rec = {meta_p0, reg_data_p0, mem_data_p0, cycle_cnt};
    assign {head_meta, out_reg_data, out_mem_data, out_cycle} = head_rec;
`else
    assign push_rec  = {meta_p0, reg_data_p0, mem_data_p0};
    assign {head_meta, out_reg_data, out_mem_data} = head_rec;
    assign out_cycle = '0;
`endif

    assign pop = out_valid && out_ready;

    trace_fifo #(
        .WIDTH(REC_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (evt_p0),
        .push_data(push_rec),
        .pop      (pop),
        .head_data(head_rec),
        .head_vld (out_valid),
        .full     (full),
        .empty    (empty)
    );

    assign out_kind    = head_meta.kind;
    assign out_reg_num = head_meta.reg_num;
    assign out_addr    = head_meta.addr;

    // Drop accounting: only a full buffer with no simultaneous pop loses the record.
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (evt_p0 && full && !pop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

    assign drop_count = drop_cnt;

endmodule
